bit_serial_alu_seq: RTL and testbench
=====================================

Name: bit_serial_alu_seq

Overview:
- Sequencer for the 1-bit ALU slice (alu_1bit). Accepts a WIDTH-bit operation, streams operands LSB-first through the slice one bit per clock, and holds the carry between bits.
- Assembles the serial result into a parallel word and reports the final carry and zero flags.
- Sits between the bit-serial CPU control FSM and the single shared ALU slice.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted in IDLE or DONE only
op  input  2  operation: 00 ADD, 01 XOR, 10 AND, 11 OR (same encoding as the slice)
sub  input  1  subtract modifier for ADD; used only when ALU_SEQ_SUB_EN is defined
a  input  WIDTH  operand 1
b  input  WIDTH  operand 2
alu_rs1  output  1  bit to slice rs1
alu_rs2  output  1  bit to slice rs2
alu_cin  output  1  carry to slice carry_in
alu_op  output  2  op to slice alu_op
alu_result  input  1  slice result
alu_cout  input  1  slice carry_out
busy  output  1  high while bits are being processed
done  output  1  one-cycle completion pulse
result  output  WIDTH  assembled result; held until the next accepted start
carry  output  1  final carry-out (0 for logic ops)
zero  output  1  result == 0

Behaviour:
- States: IDLE, RUN, DONE. Reset enters IDLE.
- On reset, all of the following clear to 0: result, carry, zero, busy, done, the alu_* outputs, the bit counter and the operand shift registers.
- Start accepted (IDLE or DONE with start=1 at the edge):
  - latch a into sh_a, b into sh_b, and op into op_q;
  - clear the bit counter to 0;
  - load the carry flop with 0 (see Optional Feature for subtract);
  - go to RUN.
- Start is ignored while in RUN. Start is level-sampled; no edge detection.
- RUN, one bit per cycle, bit i = counter:
  - outputs: alu_rs1 = sh_a[0], alu_rs2 = sh_b[0], alu_cin = carry flop, alu_op = op_q;
  - at each edge: sh_a and sh_b shift right; the result shift register shifts right with alu_result entering the MSB; carry flop <= alu_cout; counter increments;
  - on the edge where counter == WIDTH-1, go to DONE.
- Timing: start sampled at the end of cycle 0; cycles 1..WIDTH are RUN with busy=1; cycle WIDTH+1 is DONE with done=1 and busy=0. Latency is WIDTH+1 cycles from start to done.
- DONE:
  - result holds the full word;
  - carry = carry flop if op_q==00, else 0;
  - zero = (result==0), registered and valid from DONE onward;
  - next state is IDLE, or RUN if start=1.
- Outside RUN: alu_rs1, alu_rs2 and alu_cin are 0, and alu_op holds op_q.
- result, carry and zero stay stable outside RUN. During RUN, result holds partial shift contents and is not valid.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs cleared; no done pulse is issued.
- Widths: counter is $clog2(WIDTH) bits wide. Arithmetic wraps modulo 2^WIDTH, with the overflow bit reported in carry.

Optional Feature:
- Macro: ALU_SEQ_SUB_EN.
- Defined: when a start is accepted with op==00 and sub==1:
  - the carry flop loads 1;
  - alu_rs2 is driven as ~sh_b[0] throughout RUN;
  - result = a - b mod 2^WIDTH;
  - carry = 1 means no borrow (a >= b unsigned).
- Not defined: the sub input is ignored and op 00 always performs ADD with carry-in 0. The port remains present so integration is identical in both builds.

Test Plan:
- WIDTH=8, slice model attached. ADD a=8'h3C, b=8'h0F -> busy for cycles 1..8; done pulse in cycle 9; result 8'h4B, carry 0, zero 0.
- ADD 8'hFF + 8'h01 -> result 8'h00, carry 1, zero 1. Then XOR 8'hA5^8'h0F -> 8'hAA, carry 0. Then AND 8'hF0 & 8'h3C -> 8'h30. Then OR 8'h81 | 8'h18 -> 8'h99.
- Start pulsed again in cycle 4 of an ADD with different operands -> ignored; original result is returned and done is asserted exactly once.
- Back-to-back: start held high through the DONE cycle -> second op begins the next cycle. Its done arrives WIDTH+1 cycles after the first done, and the first result is visible during the first DONE cycle.
- rst asserted in cycle 5 of a RUN -> busy, done, result, carry and zero all go to 0 asynchronously. The FSM is in IDLE, no done pulse follows, and a subsequent ADD 8'h01+8'h01 gives 8'h02.
- Subtract, op=00, sub=1, a=8'h05, b=8'h07:
  - with ALU_SEQ_SUB_EN -> 8'hFE, carry 0; repeating with a=8'h07, b=8'h05 -> 8'h02, carry 1;
  - without the macro -> 8'h0C, carry 0.

Source files
------------

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: drives a shared 1-bit ALU slice through a WIDTH-bit
// operation, one bit per clock, LSB first. The carry is held between bits,
// and the serial result is reassembled into a parallel word with carry and
// zero flags.
// Optional build macro: ALU_SEQ_SUB_EN enables subtract (op 00 with sub=1,
// computed as a + ~b + 1).
module bit_serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             alu_rs1,
   output logic             alu_rs2,
   output logic             alu_cin,
   output logic [1:0]       alu_op,
   input  logic             alu_result,
   input  logic             alu_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [1:0]       op_q;
   logic             cy;
   logic             accept;
   logic             last_bit;
   logic             sub_load;
   logic             sub_q;

   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign res_next = {alu_result, res_sh[WIDTH-1:1]};
   assign result   = res_sh;

`ifdef ALU_SEQ_SUB_EN
   // A subtract is an ADD whose carry starts at 1 and whose second operand is inverted.
   assign sub_load = (op == 2'b00) && sub;

   // Remember whether the current operation is a subtract, for the rs2 inversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else if (accept) begin
         sub_q <= sub_load;
      end
   end
`else
   logic unused_sub;

   // Without subtract support the sub input is ignored; the port stays for integration.
   assign unused_sub = sub;
   assign sub_load   = 1'b0;
   assign sub_q      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and slice/handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      alu_rs1   = 1'b0;
      alu_rs2   = 1'b0;
      alu_cin   = 1'b0;
      alu_op    = op_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            alu_rs1 = sh_a[0];
            alu_rs2 = sh_b[0] ^ sub_q;
            alu_cin = cy;
            if (last_bit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand and result shifters, bit counter, carry flop and final flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_a   <= '0;
         sh_b   <= '0;
         res_sh <= '0;
         op_q   <= 2'b00;
         cnt    <= '0;
         cy     <= 1'b0;
         carry  <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         sh_a <= a;
         sh_b <= b;
         op_q <= op;
         cnt  <= '0;
         cy   <= sub_load;
      end else if (state == S_RUN) begin
         sh_a   <= sh_a >> 1;
         sh_b   <= sh_b >> 1;
         res_sh <= res_next;
         cy     <= alu_cout;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            // Flags are captured on the final edge so they are valid from DONE onward.
            carry <= (op_q == 2'b00) && alu_cout;
            zero  <= (res_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: table-driven and scoreboarded checks for the
// bit-serial ALU sequencer, with a behavioural 1-bit ALU slice attached.
module tb_bit_serial_alu_seq;

   localparam int WIDTH = 8;
   localparam int NVEC  = 11;

   typedef struct {
      logic [1:0]       op;
      logic             sub;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_r;
      logic             exp_c;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] r;
      logic             c;
      logic             z;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [1:0]       op;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             alu_rs1;
   logic             alu_rs2;
   logic             alu_cin;
   logic [1:0]       alu_op;
   logic             alu_result;
   logic             alu_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;

   int   checks    = 0;
   int   errors    = 0;
   int   done_seen = 0;
   int   n_ops     = 0;
   int   cyc       = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vec[NVEC];

   bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .sub        (sub),
      .a          (a),
      .b          (b),
      .alu_rs1    (alu_rs1),
      .alu_rs2    (alu_rs2),
      .alu_cin    (alu_cin),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .carry      (carry),
      .zero       (zero)
   );

   // Behavioural 1-bit ALU slice.
   always_comb begin
      alu_result = 1'b0;
      alu_cout   = 1'b0;
      case (alu_op)
         2'b00: begin
            alu_result = alu_rs1 ^ alu_rs2 ^ alu_cin;
            alu_cout   = (alu_rs1 & alu_rs2) | (alu_cin & (alu_rs1 ^ alu_rs2));
         end
         2'b01: alu_result = alu_rs1 ^ alu_rs2;
         2'b10: alu_result = alu_rs1 & alu_rs2;
         default: alu_result = alu_rs1 | alu_rs2;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done pulse with no pending operation (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check("sb_result", 32'(result), 32'(mon_e.r));
            check("sb_carry", 32'(carry), 32'(mon_e.c));
            check("sb_zero", 32'(zero), 32'(mon_e.z));
         end
      end
   end

   task automatic push_exp(input logic [WIDTH-1:0] r, input logic c);
      exp_t e;
      e.r = r;
      e.c = c;
      e.z = (r == '0);
      sb.push_back(e);
      n_ops++;
   endtask

   task automatic drive_start(input logic [1:0] o, input logic s,
                              input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      op    = o;
      sub   = s;
      a     = av;
      b     = bv;
      start = 1'b1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Runs one full operation from an idle state and checks the cycle timing.
   task automatic do_op(input vec_t v);
      logic bad;
      bad = 1'b0;
      drive_start(v.op, v.sub, v.a, v.b);
      push_exp(v.exp_r, v.exp_c);
      step();
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      for (int i = 1; i <= WIDTH; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
         step();
      end
      check("busy_window", 32'(bad), 32'd0);
      check("done_cycle", {30'd0, done, busy}, 32'b10);
      step();
      check("idle_after_done", {30'd0, done, busy}, 32'd0);
      check("result_hold", 32'(result), 32'(v.exp_r));
      check("alu_op_hold", 32'(alu_op), 32'(v.op));
      check("alu_bits_idle", {29'd0, alu_rs1, alu_rs2, alu_cin}, 32'd0);
   endtask

   initial begin
      int d0;
      int t_first;
      logic bad;

      vec[0]  = '{2'b00, 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0};
      vec[1]  = '{2'b00, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
      vec[2]  = '{2'b01, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0};
      vec[3]  = '{2'b10, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0};
      vec[4]  = '{2'b11, 1'b0, 8'h81, 8'h18, 8'h99, 1'b0};
`ifdef ALU_SEQ_SUB_EN
      vec[5]  = '{2'b00, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0};
      vec[6]  = '{2'b00, 1'b1, 8'h07, 8'h05, 8'h02, 1'b1};
`else
      vec[5]  = '{2'b00, 1'b1, 8'h05, 8'h07, 8'h0C, 1'b0};
      vec[6]  = '{2'b00, 1'b1, 8'h07, 8'h05, 8'h0C, 1'b0};
`endif
      vec[7]  = '{2'b00, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
      vec[8]  = '{2'b10, 1'b0, 8'h55, 8'hAA, 8'h00, 1'b0};
      vec[9]  = '{2'b00, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
      vec[10] = '{2'b01, 1'b1, 8'h0F, 8'h0F, 8'h00, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) step();
      check("reset_flags", {27'd0, busy, done, carry, zero, 1'b0}, 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_alu", {27'd0, alu_rs1, alu_rs2, alu_cin, alu_op}, 32'd0);
      #2 rst = 1'b0;
      step();

      // Table-driven operations.
      for (int i = 0; i < NVEC; i++) begin
         do_op(vec[i]);
      end

      // A start pulse in RUN cycle 4 is ignored.
      d0 = done_seen;
      drive_start(2'b00, 1'b0, 8'h10, 8'h20);
      push_exp(8'h30, 1'b0);
      step();
      start = 1'b0;
      repeat (3) step();
      drive_start(2'b01, 1'b0, 8'h55, 8'h55);
      step();
      start = 1'b0;
      repeat (WIDTH) step();
      check("ignored_start_done_count", 32'(done_seen - d0), 32'd1);
      check("ignored_start_sb_empty", 32'(sb.size()), 32'd0);

      // Back-to-back: restart from the DONE cycle.
      drive_start(2'b00, 1'b0, 8'h12, 8'h34);
      push_exp(8'h46, 1'b0);
      step();
      start = 1'b0;
      repeat (WIDTH) step();
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_first_result", 32'(result), 32'h46);
      t_first = cyc;
      drive_start(2'b11, 1'b0, 8'h0F, 8'hF0);
      push_exp(8'hFF, 1'b0);
      step();
      start = 1'b0;
      check("b2b_second_busy", 32'(busy), 32'd1);
      bad = 1'b0;
      for (int i = 1; i < WIDTH; i++) begin
         step();
         if (done !== 1'b0) bad = 1'b1;
      end
      check("b2b_no_early_done", 32'(bad), 32'd0);
      step();
      check("b2b_second_done", 32'(done), 32'd1);
      check("b2b_done_spacing", 32'(cyc - t_first), 32'(WIDTH + 1));
      step();

      // Reset in RUN cycle 5 aborts the operation.
      drive_start(2'b00, 1'b0, 8'h33, 8'h44);
      step();
      start = 1'b0;
      repeat (4) step();
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_flags", {28'd0, busy, done, carry, zero}, 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_alu", {27'd0, alu_rs1, alu_rs2, alu_cin, alu_op}, 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      d0 = done_seen;
      repeat (WIDTH + 2) step();
      check("abort_no_done", 32'(done_seen - d0), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      do_op('{2'b00, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0});

      check("sb_drained", 32'(sb.size()), 32'd0);
      check("done_total", 32'(done_seen), 32'(n_ops));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
